operand_serial_feeder: RTL and testbench
========================================

OPERAND_SERIAL_FEEDER -- requirements
Module: operand_serial_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand bit width (legal range 2..32).
REQ-002 SHALL have port clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports op0_in, op1_in, op2_in, op3_in  input  WIDTH each  four parallel operands, unsigned.
REQ-005 SHALL have port op_valid_in  input  1  operand set offered.
REQ-006 SHALL have port op_ready_out  output  1  operand set accepted when op_valid_in & op_ready_out.
REQ-007 SHALL have ports a0_out, a1_out, a2_out, a3_out  output  1 each  current serial bit of op0..op3; feed a0_in..a3_in of the four-input full adder.
REQ-008 SHALL have port bit_valid_out  output  1  serial beat present.
REQ-009 SHALL have port bit_ready_in  input  1  downstream accepts beat when bit_valid_out & bit_ready_in.
REQ-010 SHALL have port first_out  output  1  beat 0 of a frame; downstream clears its two carry registers.
REQ-011 SHALL have port last_out  output  1  final beat of a frame.
REQ-012 SHALL have port busy_out  output  1  frame in progress.

Function
REQ-013 SHALL serialise each accepted operand set as one frame of FRAME_LEN = WIDTH+2 beats, LSB first.
REQ-014 SHALL drive beat k (0..WIDTH-1) as a<i>_out = op<i>[k]; beats WIDTH and WIDTH+1 as all a<i>_out = 0 (carry flush, sum of four WIDTH-bit values needs WIDTH+2 bits).
REQ-015 SHALL use FSM states IDLE, SHIFT, FLUSH: IDLE->SHIFT on operand accept; SHIFT->FLUSH after beat WIDTH-1 accepted; FLUSH->IDLE after beat WIDTH+1 accepted, or FLUSH->SHIFT if a new set is accepted on that same cycle.
REQ-016 SHALL assert op_ready_out in IDLE, and in FLUSH on the final beat while bit_ready_in=1; deassert otherwise.
REQ-017 SHALL present beat 0 of a newly accepted set on the cycle after acceptance (latency 1); back-to-back frames have zero idle beats.
REQ-018 SHALL hold a*_out, first_out, last_out and bit_valid_out stable while bit_valid_out=1 and bit_ready_in=0.
REQ-019 SHALL assert bit_valid_out in SHIFT and FLUSH only; first_out only on beat 0; last_out only on beat WIDTH+1.
REQ-020 SHALL assert busy_out in SHIFT and FLUSH.
REQ-021 SHALL ignore op_valid_in while op_ready_out=0; held operand inputs are not sampled.
REQ-022 SHALL drive all outputs from registers; beat counter width $clog2(WIDTH+2), no wrap within a frame.

Reset
REQ-023 SHALL, on rst_in=1 at a clock edge, enter IDLE, clear counter and shift registers, set a*_out, bit_valid_out, first_out, last_out, busy_out to 0 and op_ready_out to 1 on the next cycle.
REQ-024 SHALL abort a frame on reset mid-operation without emitting last_out; rst_in has priority over every handshake.

Structure
REQ-025 SHALL take the state enum (IDLE, SHIFT, FLUSH) and the FRAME_LEN derivation from the shared package four_input_adder_pkg.
REQ-026 SHALL instantiate sub-module serial_shift_register (WIDTH-bit parallel-load, shift-right on enable) once per operand, four instances.

Verification
REQ-027 SHALL check WIDTH=8, ops all 0xFF, bit_ready_in=1: beats 0..7 a*=1, beats 8,9 a*=0, first_out beat 0, last_out beat 9; adder+reassembly gives 0x3FC.
REQ-028 SHALL check ops 0x01,0x02,0x04,0x08: a0_out=1 only beat 0, a1 only beat 1, a2 only beat 2, a3 only beat 3; sum 0x00F.
REQ-029 SHALL check bit_ready_in=0 during beats 3..5: outputs frozen at beat 3 values, frame still exactly 10 accepted beats.
REQ-030 SHALL check op_valid_in held with two sets (0x12.., 0x34..): second frame's first_out on cycle after first frame's last_out, no bubble.
REQ-031 SHALL check rst_in pulsed at beat 4: next cycle bit_valid_out=0, busy_out=0, op_ready_out=1, last_out never asserted.
REQ-032 SHALL check op_valid_in toggled with new values mid-frame: ignored, emitted bits match the originally accepted set.

Source files
------------

// File: rtl/four_input_adder_pkg.sv
// ---------------------------------------------------------------------------
// four_input_adder_pkg
// Shared definitions for the serial four-operand adder datapath.
//   feeder_state_e  : operand feeder FSM states (IDLE, SHIFT, FLUSH)
//   FLUSH_BEATS     : zero beats appended to every frame so the downstream
//                     serial adder can drain its two carry bits
//   frame_len()     : beats per frame for a given operand width
//   beat_cnt_width(): bits needed to count every beat of one frame
// ---------------------------------------------------------------------------
package four_input_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } feeder_state_e;

    // Four WIDTH-bit addends sum to at most WIDTH+2 bits, so two extra
    // all-zero beats are enough to push out both carry registers.
    localparam int FLUSH_BEATS = 2;

    function automatic int frame_len(input int width);
        return width + FLUSH_BEATS;
    endfunction

    function automatic int beat_cnt_width(input int width);
        return $clog2(width + FLUSH_BEATS);
    endfunction

endpackage

// File: rtl/operand_serial_feeder_if.sv
// ---------------------------------------------------------------------------
// operand_serial_feeder_if
// Bundles the operand-side and serial-side handshakes of the feeder.
//   op0_in..op3_in, op_valid_in / op_ready_out : parallel operand set
//   a0_out..a3_out, bit_valid_out / bit_ready_in: serial beat stream
//   first_out, last_out                          : frame delimiters
//   busy_out                                     : frame in progress
// Modports:
//   master : the feeder itself (produces the serial stream)
//   slave  : the environment (supplies operands, consumes beats)
// ---------------------------------------------------------------------------
interface operand_serial_feeder_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] op0_in;
    logic [WIDTH-1:0] op1_in;
    logic [WIDTH-1:0] op2_in;
    logic [WIDTH-1:0] op3_in;
    logic             op_valid_in;
    logic             op_ready_out;
    logic             a0_out;
    logic             a1_out;
    logic             a2_out;
    logic             a3_out;
    logic             bit_valid_out;
    logic             bit_ready_in;
    logic             first_out;
    logic             last_out;
    logic             busy_out;

    modport master (
        input  op0_in, op1_in, op2_in, op3_in, op_valid_in, bit_ready_in,
        output op_ready_out, a0_out, a1_out, a2_out, a3_out,
               bit_valid_out, first_out, last_out, busy_out
    );

    modport slave (
        output op0_in, op1_in, op2_in, op3_in, op_valid_in, bit_ready_in,
        input  op_ready_out, a0_out, a1_out, a2_out, a3_out,
               bit_valid_out, first_out, last_out, busy_out
    );

endinterface

// File: rtl/serial_shift_register.sv
// ---------------------------------------------------------------------------
// serial_shift_register
// WIDTH-bit parallel-load register that shifts right (towards bit 0) on
// shift_en, filling with zeros from the top. bit_out is the current LSB.
// Once WIDTH shifts have happened the register is all zero, which is what
// provides the flush beats at the end of a frame without extra muxing.
//   clk      : clock
//   srst     : synchronous active-high reset (clears the register)
//   load     : load din (wins over shift_en)
//   shift_en : shift right by one
//   din      : parallel operand
//   bit_out  : registered serial bit
// ---------------------------------------------------------------------------
module serial_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out
);

    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= din;
        end else if (shift_en) begin
            data_reg <= {1'b0, data_reg[WIDTH-1:1]};
        end
    end

    assign bit_out = data_reg[0];

endmodule

// File: rtl/operand_serial_feeder.sv
// ---------------------------------------------------------------------------
// operand_serial_feeder
// Accepts four parallel unsigned operands and streams them LSB first, one
// bit of each operand per beat, into a four-input serial full adder. Each
// frame is WIDTH data beats followed by two all-zero carry-flush beats.
//   clk_in : clock
//   rst_in : synchronous active-high reset
//   bus    : operand_serial_feeder_if.master (operand handshake, serial
//            beat handshake, first/last/busy status)
// Beat 0 of an accepted set appears the cycle after acceptance; a new set
// can be taken on the final beat of the current frame, so consecutive
// frames run with no idle beat between them.
// ---------------------------------------------------------------------------
module operand_serial_feeder
    import four_input_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    operand_serial_feeder_if.master bus
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CNT_W     = beat_cnt_width(WIDTH);

    localparam logic [CNT_W-1:0] LAST_DATA_BEAT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT      = CNT_W'(FRAME_LEN - 1);

    feeder_state_e    state_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic             bit_valid_reg;
    logic             first_reg;
    logic             last_reg;
    logic             busy_reg;
    logic             idle_reg;

    logic             beat_fire;
    logic             op_fire;
    logic             op_ready;
    logic [WIDTH-1:0] op_arr [4];
    logic [3:0]       a_bits;

    // idle_reg and last_reg are registered; the final-beat term has to be
    // qualified by the live bit_ready_in so the next set is accepted in
    // exactly the cycle the last beat leaves, giving gap-free frames.
    assign op_ready  = idle_reg | (last_reg & bus.bit_ready_in);
    assign op_fire   = bus.op_valid_in & op_ready;
    assign beat_fire = bit_valid_reg & bus.bit_ready_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            bit_valid_reg <= 1'b0;
            first_reg     <= 1'b0;
            last_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            idle_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_fire) begin
                        state_reg     <= SHIFT;
                        beat_cnt_reg  <= '0;
                        bit_valid_reg <= 1'b1;
                        first_reg     <= 1'b1;
                        last_reg      <= 1'b0;
                        busy_reg      <= 1'b1;
                        idle_reg      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (beat_fire) begin
                        first_reg    <= 1'b0;
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                        if (beat_cnt_reg == LAST_DATA_BEAT) begin
                            state_reg <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (beat_fire) begin
                        if (beat_cnt_reg == LAST_BEAT) begin
                            if (op_fire) begin
                                // Back-to-back: next frame starts right away.
                                state_reg     <= SHIFT;
                                beat_cnt_reg  <= '0;
                                bit_valid_reg <= 1'b1;
                                first_reg     <= 1'b1;
                                last_reg      <= 1'b0;
                                busy_reg      <= 1'b1;
                                idle_reg      <= 1'b0;
                            end else begin
                                state_reg     <= IDLE;
                                beat_cnt_reg  <= '0;
                                bit_valid_reg <= 1'b0;
                                first_reg     <= 1'b0;
                                last_reg      <= 1'b0;
                                busy_reg      <= 1'b0;
                                idle_reg      <= 1'b1;
                            end
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                            last_reg     <= ((beat_cnt_reg + CNT_W'(1)) == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    beat_cnt_reg  <= '0;
                    bit_valid_reg <= 1'b0;
                    first_reg     <= 1'b0;
                    last_reg      <= 1'b0;
                    busy_reg      <= 1'b0;
                    idle_reg      <= 1'b1;
                end
            endcase
        end
    end

    assign op_arr[0] = bus.op0_in;
    assign op_arr[1] = bus.op1_in;
    assign op_arr[2] = bus.op2_in;
    assign op_arr[3] = bus.op3_in;

    // One shift register per operand lane. A load always coincides with
    // either IDLE or the final (already all-zero) beat, so load-over-shift
    // priority never loses a data bit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            serial_shift_register #(
                .WIDTH (WIDTH)
            ) u_sr (
                .clk      (clk_in),
                .srst     (rst_in),
                .load     (op_fire),
                .shift_en (beat_fire),
                .din      (op_arr[gi]),
                .bit_out  (a_bits[gi])
            );
        end
    endgenerate

    assign bus.a0_out        = a_bits[0];
    assign bus.a1_out        = a_bits[1];
    assign bus.a2_out        = a_bits[2];
    assign bus.a3_out        = a_bits[3];
    assign bus.op_ready_out  = op_ready;
    assign bus.bit_valid_out = bit_valid_reg;
    assign bus.first_out     = first_reg;
    assign bus.last_out      = last_reg;
    assign bus.busy_out      = busy_reg;

endmodule

// File: tb/tb_operand_serial_feeder.sv
// ---------------------------------------------------------------------------
// tb_operand_serial_feeder
// Drives operand sets into operand_serial_feeder (WIDTH=8) and checks the
// serial stream against a frame-level reference: each accepted set becomes
// a queue of expected beats plus the expected four-way sum. A negedge
// monitor compares every cycle and reassembles the sum through a behavioural
// four-input serial adder.
// ---------------------------------------------------------------------------
module tb_operand_serial_feeder;

    localparam int W         = 8;
    localparam int FRAME_LEN = W + 2;

    typedef struct packed {
        logic [3:0] a;
        logic       first;
        logic       last;
    } beat_t;

    logic clk;
    logic rst;

    operand_serial_feeder_if #(.WIDTH(W)) bus ();

    operand_serial_feeder #(.WIDTH(W)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    beat_t exp_q[$];
    int    sum_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    frames      = 0;
    int    acc         = 0;
    int    carry       = 0;
    int    s           = 0;
    int    beat_idx    = 0;
    bit    armed       = 1'b0;
    bit    accept_flag = 1'b0;
    bit    rand_ready  = 1'b0;
    bit    forced_ready = 1'b1;
    logic  exp_valid;
    logic  exp_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: either random back-pressure or a directed level.
    initial begin
        bus.bit_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.bit_ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (armed) begin
            exp_valid = (exp_q.size() != 0);
            exp_ready = !exp_valid || (exp_q.size() == 1 && bus.bit_ready_in);
            check("bit_valid", 16'(bus.bit_valid_out), 16'(exp_valid));
            check("busy",      16'(bus.busy_out),      16'(exp_valid));
            check("op_ready",  16'(bus.op_ready_out),  16'(exp_ready));
            if (exp_valid) begin
                check("beat_bits", 16'({bus.a3_out, bus.a2_out, bus.a1_out, bus.a0_out}),
                      16'(exp_q[0].a));
                check("first", 16'(bus.first_out), 16'(exp_q[0].first));
                check("last",  16'(bus.last_out),  16'(exp_q[0].last));
            end else begin
                check("idle_outs", 16'({bus.a3_out, bus.a2_out, bus.a1_out, bus.a0_out,
                                        bus.first_out, bus.last_out}), 16'(0));
            end

            if (rst) begin
                exp_q.delete();
                sum_q.delete();
                acc   = 0;
                carry = 0;
            end else begin
                if (exp_valid && bus.bit_ready_in) begin
                    beat_idx = FRAME_LEN - exp_q.size();
                    s = int'(bus.a0_out) + int'(bus.a1_out) + int'(bus.a2_out)
                      + int'(bus.a3_out) + carry;
                    acc   = acc | ((s % 2) << beat_idx);
                    carry = s / 2;
                    if (exp_q[0].last) begin
                        frames++;
                        $display("frame %0d: reassembled sum 0x%03h", frames, acc);
                        check("frame_sum", 16'(acc), 16'(sum_q[0]));
                        void'(sum_q.pop_front());
                        acc   = 0;
                        carry = 0;
                    end
                    void'(exp_q.pop_front());
                end
                if (bus.op_valid_in && exp_ready) begin
                    for (int k = 0; k < FRAME_LEN; k++) begin
                        beat_t b;
                        b.a = 4'b0000;
                        if (k < W) begin
                            b.a = {bus.op3_in[k], bus.op2_in[k], bus.op1_in[k], bus.op0_in[k]};
                        end
                        b.first = (k == 0);
                        b.last  = (k == FRAME_LEN - 1);
                        exp_q.push_back(b);
                    end
                    sum_q.push_back(int'(bus.op0_in) + int'(bus.op1_in)
                                  + int'(bus.op2_in) + int'(bus.op3_in));
                    accept_flag = 1'b1;
                end
            end
        end
    end

    // Offer a set and wait (bounded) until it is accepted; returns at posedge+1
    // with op_valid_in still high so callers can chain sets back-to-back.
    task automatic send_set(input logic [W-1:0] v0, input logic [W-1:0] v1,
                            input logic [W-1:0] v2, input logic [W-1:0] v3);
        int c = 0;
        bus.op0_in      = v0;
        bus.op1_in      = v1;
        bus.op2_in      = v2;
        bus.op3_in      = v3;
        bus.op_valid_in = 1'b1;
        accept_flag     = 1'b0;
        while (!accept_flag && c < 400) begin
            @(posedge clk);
            c++;
        end
        if (!accept_flag) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: set not accepted after %0d cycles", c);
        end
        #1;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (exp_q.size() != 0 && c < 400) begin
            @(posedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.op_valid_in = 1'b0;
        bus.op0_in      = '0;
        bus.op1_in      = '0;
        bus.op2_in      = '0;
        bus.op3_in      = '0;
        repeat (2) @(posedge clk);
        armed = 1'b1;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All ones: data beats 1111, flush beats 0000, sum 0x3FC.
        send_set(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        bus.op_valid_in = 1'b0;
        wait_idle();

        // Walking one across lanes: sum 0x00F.
        send_set(8'h01, 8'h02, 8'h04, 8'h08);
        bus.op_valid_in = 1'b0;
        wait_idle();

        // Back-pressure: hold beat 3 for three cycles.
        send_set(8'hA5, 8'h3C, 8'hC3, 8'h5A);
        bus.op_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        forced_ready = 1'b0;
        repeat (3) @(posedge clk);
        forced_ready = 1'b1;
        #1;
        wait_idle();

        // Two sets offered back-to-back with op_valid_in held.
        send_set(8'h12, 8'h13, 8'h14, 8'h15);
        send_set(8'h34, 8'h35, 8'h36, 8'h37);
        bus.op_valid_in = 1'b0;
        wait_idle();

        // Reset pulse while beat 4 is presented.
        send_set(8'h9B, 8'h6E, 8'hF0, 8'h0F);
        bus.op_valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle();

        // New values toggled mid-frame must be ignored.
        send_set(8'hC6, 8'h21, 8'h7D, 8'hE8);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.op_valid_in = 1'($urandom_range(0, 1));
            bus.op0_in      = W'($urandom);
            bus.op1_in      = W'($urandom);
            bus.op2_in      = W'($urandom);
            bus.op3_in      = W'($urandom);
        end
        bus.op_valid_in = 1'b0;
        wait_idle();

        // Random sets, random gaps, random downstream back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_set(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                bus.op_valid_in = 1'b0;
                for (int g = 0; g < int'($urandom_range(0, 12)); g++) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus.op_valid_in = 1'b0;
        wait_idle();
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
